// File: rtl/ct_fcnvt_issue_arb_if.sv
// ---------------------------------------------------------------------------
// ct_fcnvt_issue_arb_if
//   Bundles the request, grant, control and stage-status signals of the
//   FP-convert issue arbiter.
//   master : requester / writeback side (drives requests, wb_stall, flush)
//   slave  : arbiter side (drives grants, pipedowns, stage tags, status)
//   Optional perf counter signals exist only with FCNVT_ARB_PERF_CNT_EN.
// ---------------------------------------------------------------------------
interface ct_fcnvt_issue_arb_if #(
   parameter int unsigned TAG_W = 7
);
   logic             req0_vld;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_vld;
   logic [TAG_W-1:0] req1_tag;
   logic             gnt0;
   logic             gnt1;
   logic             wb_stall;
   logic             flush;
   logic             ex1_pipedown;
   logic             ex2_pipedown;
   logic             ex3_pipedown;
   logic [TAG_W-1:0] ex1_tag;
   logic [TAG_W-1:0] ex2_tag;
   logic [TAG_W-1:0] ex3_tag;
   logic             ex3_src;
   logic             ex3_wb_vld;
   logic             busy;
`ifdef FCNVT_ARB_PERF_CNT_EN
   logic             perf_clr;
   logic [15:0]      perf_gnt_cnt;
   logic [15:0]      perf_stall_cnt;
   logic [15:0]      perf_conflict_cnt;
`endif

   modport master (
      output req0_vld, req0_tag, req1_vld, req1_tag, wb_stall, flush,
`ifdef FCNVT_ARB_PERF_CNT_EN
      output perf_clr,
      input  perf_gnt_cnt, perf_stall_cnt, perf_conflict_cnt,
`endif
      input  gnt0, gnt1, ex1_pipedown, ex2_pipedown, ex3_pipedown,
      input  ex1_tag, ex2_tag, ex3_tag, ex3_src, ex3_wb_vld, busy
   );

   modport slave (
      input  req0_vld, req0_tag, req1_vld, req1_tag, wb_stall, flush,
`ifdef FCNVT_ARB_PERF_CNT_EN
      input  perf_clr,
      output perf_gnt_cnt, perf_stall_cnt, perf_conflict_cnt,
`endif
      output gnt0, gnt1, ex1_pipedown, ex2_pipedown, ex3_pipedown,
      output ex1_tag, ex2_tag, ex3_tag, ex3_src, ex3_wb_vld, busy
   );
endinterface

// File: rtl/ct_fcnvt_issue_arb.sv
// ---------------------------------------------------------------------------
// ct_fcnvt_issue_arb
//   Round-robin arbiter sharing the single vector FP-convert pipe (EX1-EX3)
//   between issue requesters pipe6 (req0) and pipe7 (req1). Tracks valid,
//   tag and source of each in-flight op, drives per-stage pipedown strobes,
//   holds the whole pipe on writeback back-pressure, kills it on flush.
//
//   Ports:
//     forever_cpuclk : clock
//     cpurst         : asynchronous reset, active high
//     arb            : ct_fcnvt_issue_arb_if.slave
//                      req0/1_vld/tag, wb_stall, flush  (in)
//                      gnt0/1 (combinational), exN_pipedown, exN_tag,
//                      ex3_src, ex3_wb_vld, busy        (out)
//
//   Optional: define FCNVT_ARB_PERF_CNT_EN to add saturating 16-bit
//   grant / stall / conflict counters with a synchronous perf_clr.
// ---------------------------------------------------------------------------
module ct_fcnvt_issue_arb #(
   parameter int unsigned TAG_W = 7
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   ct_fcnvt_issue_arb_if.slave   arb
);

   typedef enum logic {
      RR_PIPE6 = 1'b0,
      RR_PIPE7 = 1'b1
   } rr_e;

   rr_e              rr_ptr;
   rr_e              rr_nxt;

   logic             ex1_vld, ex2_vld, ex3_vld;
   logic [TAG_W-1:0] ex1_tag_q, ex2_tag_q, ex3_tag_q;
   logic             ex1_src, ex2_src, ex3_src_q;

   logic             adv;
   logic             permit;
   logic             gnt0_c, gnt1_c, gnt_any;
   logic             win_src;
   logic [TAG_W-1:0] win_tag;
   logic             ex1_en, ex2_en, ex3_en;

   // ------------------------------------------------------------------
   // Arbitration. Grants are withheld while the pipe cannot advance,
   // during flush, and while reset is held so all outputs read 0.
   // ------------------------------------------------------------------
   always_comb begin
      adv    = ~(ex3_vld & arb.wb_stall);
      permit = adv & ~arb.flush & ~cpurst;
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (permit) begin
         if (arb.req0_vld && arb.req1_vld) begin
            if (rr_ptr == RR_PIPE7) gnt1_c = 1'b1;
            else                    gnt0_c = 1'b1;
         end else begin
            gnt0_c = arb.req0_vld;
            gnt1_c = arb.req1_vld;
         end
      end
      gnt_any = gnt0_c | gnt1_c;
      win_src = gnt1_c;
      win_tag = gnt1_c ? arb.req1_tag : arb.req0_tag;

      // Prefer the loser next time; no grant leaves the pointer alone.
      rr_nxt = rr_ptr;
      if (gnt0_c)      rr_nxt = RR_PIPE7;
      else if (gnt1_c) rr_nxt = RR_PIPE6;
   end

   // Tag/src registers load only when something moves into the stage.
   always_comb begin
      ex1_en = adv & ~arb.flush & (ex1_vld | gnt_any);
      ex2_en = adv & ~arb.flush & (ex2_vld | ex1_vld);
      ex3_en = adv & ~arb.flush & (ex3_vld | ex2_vld);
   end

   // ------------------------------------------------------------------
   // Stage valids and round-robin pointer
   // ------------------------------------------------------------------
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         ex1_vld <= 1'b0;
         ex2_vld <= 1'b0;
         ex3_vld <= 1'b0;
         rr_ptr  <= RR_PIPE6;
      end else begin
         rr_ptr <= rr_nxt;
         if (arb.flush) begin
            ex1_vld <= 1'b0;
            ex2_vld <= 1'b0;
            ex3_vld <= 1'b0;
         end else if (adv) begin
            ex1_vld <= gnt_any;
            ex2_vld <= ex1_vld;
            ex3_vld <= ex2_vld;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage tag / source payload
   // ------------------------------------------------------------------
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         ex1_tag_q <= '0;
         ex2_tag_q <= '0;
         ex3_tag_q <= '0;
         ex1_src   <= 1'b0;
         ex2_src   <= 1'b0;
         ex3_src_q <= 1'b0;
      end else begin
         if (ex1_en) begin
            ex1_tag_q <= win_tag;
            ex1_src   <= win_src;
         end
         if (ex2_en) begin
            ex2_tag_q <= ex1_tag_q;
            ex2_src   <= ex1_src;
         end
         if (ex3_en) begin
            ex3_tag_q <= ex2_tag_q;
            ex3_src_q <= ex2_src;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign arb.gnt0         = gnt0_c;
   assign arb.gnt1         = gnt1_c;
   assign arb.ex1_pipedown = ex1_vld;
   assign arb.ex2_pipedown = ex2_vld;
   assign arb.ex3_pipedown = ex3_vld;
   assign arb.ex1_tag      = ex1_tag_q;
   assign arb.ex2_tag      = ex2_tag_q;
   assign arb.ex3_tag      = ex3_tag_q;
   assign arb.ex3_src      = ex3_src_q;
   assign arb.ex3_wb_vld   = ex3_vld & ~arb.wb_stall;
   assign arb.busy         = ex1_vld | ex2_vld | ex3_vld;

`ifdef FCNVT_ARB_PERF_CNT_EN
   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   logic [15:0] gnt_cnt, stall_cnt, conflict_cnt;
   logic        conflict;

   assign conflict = permit & arb.req0_vld & arb.req1_vld;

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         gnt_cnt      <= '0;
         stall_cnt    <= '0;
         conflict_cnt <= '0;
      end else if (arb.perf_clr) begin
         gnt_cnt      <= '0;
         stall_cnt    <= '0;
         conflict_cnt <= '0;
      end else begin
         if (gnt_any && (gnt_cnt != '1))           gnt_cnt      <= gnt_cnt + 16'd1;
         if (!adv && (stall_cnt != '1))            stall_cnt    <= stall_cnt + 16'd1;
         if (conflict && (conflict_cnt != '1))     conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

   assign arb.perf_gnt_cnt      = gnt_cnt;
   assign arb.perf_stall_cnt    = stall_cnt;
   assign arb.perf_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_ct_fcnvt_issue_arb.sv
module tb_ct_fcnvt_issue_arb;
   localparam int unsigned TAG_W = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   ct_fcnvt_issue_arb_if #(.TAG_W(TAG_W)) bus ();

   ct_fcnvt_issue_arb #(.TAG_W(TAG_W)) dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .arb            (bus)
   );

   // ---------------- table vectors ----------------
   typedef struct {
      logic             r0;
      logic [TAG_W-1:0] t0;
      logic             r1;
      logic [TAG_W-1:0] t1;
      logic             st;
      logic             fl;
      logic             g0;
      logic             g1;
      logic [2:0]       p;     // {ex1,ex2,ex3} pipedown
      logic             wbv;
      logic [TAG_W-1:0] tag3;
      logic             src3;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r0, input logic [TAG_W-1:0] t0,
                               input logic r1, input logic [TAG_W-1:0] t1,
                               input logic st, input logic fl,
                               input logic g0, input logic g1, input logic [2:0] p,
                               input logic wbv, input logic [TAG_W-1:0] tag3,
                               input logic src3);
      vec_t v;
      v.r0 = r0; v.t0 = t0; v.r1 = r1; v.t1 = t1; v.st = st; v.fl = fl;
      v.g0 = g0; v.g1 = g1; v.p = p; v.wbv = wbv; v.tag3 = tag3; v.src3 = src3;
      return v;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic             vld;
      logic [TAG_W-1:0] tag;
      logic             src;
   } slot_t;

   slot_t m_pipe[3];
   logic  m_pref7;

   task automatic m_reset();
      for (int i = 0; i < 3; i++) m_pipe[i] = '{1'b0, '0, 1'b0};
      m_pref7 = 1'b0;
   endtask

   task automatic m_grant(output logic g0, output logic g1, output logic adv);
      logic allowed;
      adv     = !(m_pipe[2].vld && bus.wb_stall);
      allowed = adv && !bus.flush && !rst;
      g0 = 1'b0;
      g1 = 1'b0;
      if (allowed) begin
         if (bus.req0_vld && bus.req1_vld) begin
            g1 = m_pref7;
            g0 = !m_pref7;
         end else begin
            g0 = bus.req0_vld;
            g1 = bus.req1_vld;
         end
      end
   endtask

   task automatic m_step();
      logic g0, g1, adv;
      slot_t n;
      m_grant(g0, g1, adv);
      if (bus.flush) begin
         for (int i = 0; i < 3; i++) m_pipe[i].vld = 1'b0;
      end else if (adv) begin
         n.vld = g0 | g1;
         n.tag = g1 ? bus.req1_tag : bus.req0_tag;
         n.src = g1;
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = n;
      end
      if (g0) m_pref7 = 1'b1;
      if (g1) m_pref7 = 1'b0;
   endtask

   // ---------------- helpers ----------------
   task automatic drive(input logic r0, input logic [TAG_W-1:0] t0,
                        input logic r1, input logic [TAG_W-1:0] t1,
                        input logic st, input logic fl);
      bus.req0_vld = r0; bus.req0_tag = t0;
      bus.req1_vld = r1; bus.req1_tag = t1;
      bus.wb_stall = st; bus.flush    = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_vec(input string nm, input vec_t v);
      logic [6:0] act, exp;
      logic       ok;
      act = {bus.gnt0, bus.gnt1, bus.ex1_pipedown, bus.ex2_pipedown,
             bus.ex3_pipedown, bus.ex3_wb_vld, bus.busy};
      exp = {v.g0, v.g1, v.p, v.wbv, |v.p};
      ok  = (act === exp) && (!v.p[0] || (bus.ex3_tag === v.tag3 && bus.ex3_src === v.src3));
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got g0g1/p123/wbv/busy=%b tag3=%h src3=%b expected %b tag3=%h src3=%b",
                  nm, act, bus.ex3_tag, bus.ex3_src, exp, v.tag3, v.src3);
      end
   endtask

   task automatic chk_model(input string nm);
      logic g0, g1, adv;
      logic ok;
      m_grant(g0, g1, adv);
      ok = (bus.gnt0 === g0) && (bus.gnt1 === g1)
         && (bus.ex1_pipedown === m_pipe[0].vld)
         && (bus.ex2_pipedown === m_pipe[1].vld)
         && (bus.ex3_pipedown === m_pipe[2].vld)
         && (bus.ex3_wb_vld === (m_pipe[2].vld && !bus.wb_stall))
         && (bus.busy === (m_pipe[0].vld || m_pipe[1].vld || m_pipe[2].vld))
         && (!m_pipe[0].vld || bus.ex1_tag === m_pipe[0].tag)
         && (!m_pipe[1].vld || bus.ex2_tag === m_pipe[1].tag)
         && (!m_pipe[2].vld || (bus.ex3_tag === m_pipe[2].tag && bus.ex3_src === m_pipe[2].src));
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got g=%b%b p=%b%b%b tags=%h/%h/%h src3=%b expected g=%b%b p=%b%b%b tags=%h/%h/%h src3=%b at %0t",
                  nm, bus.gnt0, bus.gnt1, bus.ex1_pipedown, bus.ex2_pipedown, bus.ex3_pipedown,
                  bus.ex1_tag, bus.ex2_tag, bus.ex3_tag, bus.ex3_src,
                  g0, g1, m_pipe[0].vld, m_pipe[1].vld, m_pipe[2].vld,
                  m_pipe[0].tag, m_pipe[1].tag, m_pipe[2].tag, m_pipe[2].src, $time);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      drive(0, '0, 0, '0, 0, 0);
`ifdef FCNVT_ARB_PERF_CNT_EN
      bus.perf_clr = 1'b0;
`endif
      m_reset();

      // Single op, stall sequence, stall on empty pipe
      tbl.push_back(mk(1,'h11,0,'h00,0,0, 1,0,3'b000,0,'h00,0));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b100,0,'h00,0));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b010,0,'h00,0));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b001,1,'h11,0));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b000,0,'h00,0));
      tbl.push_back(mk(0,'h00,1,'h21,0,0, 0,1,3'b000,0,'h00,0));
      tbl.push_back(mk(1,'h22,0,'h00,0,0, 1,0,3'b100,0,'h00,0));
      tbl.push_back(mk(0,'h00,1,'h23,0,0, 0,1,3'b110,0,'h00,0));
      tbl.push_back(mk(1,'h24,0,'h00,1,0, 0,0,3'b111,0,'h21,1));
      tbl.push_back(mk(1,'h24,0,'h00,1,0, 0,0,3'b111,0,'h21,1));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b111,1,'h21,1));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b011,1,'h22,0));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b001,1,'h23,1));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b000,0,'h00,0));
      tbl.push_back(mk(0,'h00,1,'h31,1,0, 0,1,3'b000,0,'h00,0));
      tbl.push_back(mk(0,'h00,0,'h00,1,0, 0,0,3'b100,0,'h00,0));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b010,0,'h00,0));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b001,1,'h31,1));
      tbl.push_back(mk(0,'h00,0,'h00,0,0, 0,0,3'b000,0,'h00,0));

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_vec("reset_state", mk(0,'h00,0,'h00,0,0, 0,0,3'b000,0,'h00,0));
      chk("reset_tag1", 16'(bus.ex1_tag), 16'h0);
      chk("reset_src3", 16'(bus.ex3_src), 16'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r0, tbl[i].t0, tbl[i].r1, tbl[i].t1, tbl[i].st, tbl[i].fl);
         #4;
         chk_vec($sformatf("tbl[%0d]", i), tbl[i]);
         if (i == 1) chk("ex1_tag_11", 16'(bus.ex1_tag), 16'h11);
         if (i == 2) chk("ex2_tag_11", 16'(bus.ex2_tag), 16'h11);
         tick();
      end

      // Both requesters held: strict alternation starting at pipe6
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i < 4) drive(1, 7'(i + 1), 1, 7'(i + 'h41), 0, 0);
         else       drive(0, '0, 0, '0, 0, 0);
         #4;
         if (i < 4) chk($sformatf("rr_gnt[%0d]", i), {14'h0, bus.gnt0, bus.gnt1},
                        (i % 2 == 0) ? 16'b10 : 16'b01);
         if (i >= 3 && i <= 6)
            chk($sformatf("rr_src3[%0d]", i), {14'h0, bus.ex3_pipedown, bus.ex3_src},
                {14'h0, 1'b1, 1'(i - 3)});
         tick();
      end

      // Flush with stall and request pending
      do_reset();
      drive(1, 'h51, 0, '0, 0, 0); tick();
      drive(0, '0, 1, 'h52, 0, 0); tick();
      drive(1, 'h53, 0, '0, 0, 0); tick();
      drive(1, 'h54, 0, '0, 1, 1);
      #4;
      chk("flush_gnt0", {14'h0, bus.gnt0, bus.gnt1}, 16'h0);
      chk("flush_pre_p", {13'h0, bus.ex1_pipedown, bus.ex2_pipedown, bus.ex3_pipedown}, 16'b111);
      tick();
      drive(0, '0, 0, '0, 0, 0);
      #4;
      chk("flush_post_p", {13'h0, bus.ex1_pipedown, bus.ex2_pipedown, bus.ex3_pipedown}, 16'h0);
      chk("flush_busy", 16'(bus.busy), 16'h0);
      tick();
      drive(1, 'h55, 1, 'h56, 0, 0);
      #4;
      chk("flush_rr_kept", {14'h0, bus.gnt0, bus.gnt1}, 16'b01);
      tick();

      // Asynchronous reset mid-cycle
      do_reset();
      drive(1, 'h61, 0, '0, 0, 0); tick();
      drive(0, '0, 1, 'h62, 0, 0); tick();
      drive(1, 'h63, 1, 'h64, 0, 0);
      #2;
      chk("pre_rst_busy", 16'(bus.busy), 16'h1);
      rst = 1'b1;
      #1;
      chk("async_rst_out", {9'h0, bus.gnt0, bus.gnt1, bus.ex1_pipedown, bus.ex2_pipedown,
                            bus.ex3_pipedown, bus.ex3_wb_vld, bus.busy}, 16'h0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("post_rst_rr", {14'h0, bus.gnt0, bus.gnt1}, 16'b10);
      tick();

      // Randomised run against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)), 7'($urandom),
               ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
         #4;
         chk_model("rand");
         tick();
      end

`ifdef FCNVT_ARB_PERF_CNT_EN
      do_reset();
      drive(1, 'h01, 1, 'h02, 0, 0);
      for (int i = 0; i < 70000; i++) @(posedge clk);
      @(negedge clk);
      chk("perf_conflict_sat", bus.perf_conflict_cnt, 16'hFFFF);
      chk("perf_gnt_sat", bus.perf_gnt_cnt, 16'hFFFF);
      chk("perf_stall_zero", bus.perf_stall_cnt, 16'h0);
      drive(0, '0, 0, '0, 0, 0);
      bus.perf_clr = 1'b1;
      @(negedge clk);
      bus.perf_clr = 1'b0;
      chk("perf_clr", bus.perf_conflict_cnt, 16'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
